// File: rtl/rs_gf_pkg.sv
// GF(2^m) helpers shared by the Reed-Solomon syndrome datapath.
// Functions work on symbols up to GF_MAXW bits wide. The field width is
// taken from the degree of the primitive polynomial passed in, so the same
// helpers serve every SYMW from 3 to 8.
package rs_gf_pkg;

  localparam int GF_MAXW = 8;

  // Default primitive polynomials, including the x^m term.
  localparam int PRIM_POLY_W3 = 11;   // x^3+x+1
  localparam int PRIM_POLY_W4 = 19;   // x^4+x+1
  localparam int PRIM_POLY_W5 = 37;   // x^5+x^2+1
  localparam int PRIM_POLY_W6 = 67;   // x^6+x+1
  localparam int PRIM_POLY_W7 = 137;  // x^7+x^3+1
  localparam int PRIM_POLY_W8 = 285;  // x^8+x^4+x^3+x^2+1

  function automatic int default_prim_poly(input int symw);
    case (symw)
      3:       return PRIM_POLY_W3;
      4:       return PRIM_POLY_W4;
      5:       return PRIM_POLY_W5;
      6:       return PRIM_POLY_W6;
      7:       return PRIM_POLY_W7;
      default: return PRIM_POLY_W8;
    endcase
  endfunction

  // Multiply by alpha (x) once: shift left and reduce if the x^m term appears.
  function automatic logic [GF_MAXW-1:0] gf_xtime(input logic [GF_MAXW-1:0] value,
                                                  input logic [GF_MAXW:0]   poly);
    logic [GF_MAXW:0] top;
    logic [GF_MAXW:0] sh;
    top = '0;
    for (int b = 0; b <= GF_MAXW; b++) begin
      if (poly[b]) begin
        top    = '0;
        top[b] = 1'b1;
      end
    end
    sh = {value, 1'b0};
    if ((sh & top) != '0) sh = sh ^ poly;
    return sh[GF_MAXW-1:0];
  endfunction

  // Multiply by alpha^k as k chained xtime steps; with constant k this
  // collapses to a fixed XOR network.
  function automatic logic [GF_MAXW-1:0] gf_mul_xpow(input logic [GF_MAXW-1:0] value,
                                                     input int                 k,
                                                     input logic [GF_MAXW:0]   poly);
    logic [GF_MAXW-1:0] v;
    v = value;
    for (int i = 0; i < k; i++) begin
      v = gf_xtime(v, poly);
    end
    return v;
  endfunction

endpackage

// File: rtl/gf_mul_const.sv
// Combinational multiply of a GF(2^SYMW) symbol by the constant alpha^POW.
module gf_mul_const
  import rs_gf_pkg::*;
#(
  parameter int SYMW      = 4,
  parameter int PRIM_POLY = 19,
  parameter int POW       = 1
) (
  input  logic [SYMW-1:0] a,
  output logic [SYMW-1:0] y
);

  // alpha has order 2^SYMW-1, so fold large exponents to keep the chain short.
  localparam int ORDER   = (1 << SYMW) - 1;
  localparam int POW_RED = ((POW % ORDER) + ORDER) % ORDER;
  localparam logic [GF_MAXW:0] POLY = (GF_MAXW+1)'(PRIM_POLY);

  logic [GF_MAXW-1:0] a_ext;
  logic [GF_MAXW-1:0] y_ext;
  logic               unused_y;

  // Zero-extend into the package width, multiply, truncate back.
  always_comb begin
    a_ext           = '0;
    a_ext[SYMW-1:0] = a;
    y_ext           = gf_mul_xpow(a_ext, POW_RED, POLY);
    y               = y_ext[SYMW-1:0];
  end

  // Upper bits stay zero for a reduced symbol; fold them so nothing dangles.
  assign unused_y = ^y_ext;

endmodule

// File: rtl/rs_syndrome_calc.sv
// Streaming Reed-Solomon syndrome calculator over GF(2^SYMW).
// One symbol per transfer, highest-degree coefficient first; NSYN Horner
// accumulators evaluate the codeword at alpha^FCR .. alpha^(FCR+NSYN-1).
// The final syndromes are registered with a valid/ready handshake so the next
// codeword can stream in while a result waits; only the last symbol of a
// codeword stalls if the previous result has not been taken.
// Optional build macro RS_SYN_ERRCNT_EN adds a saturating count of codewords
// with a non-zero syndrome (errcnt_o, cleared by errcnt_clr_i).
module rs_syndrome_calc
  import rs_gf_pkg::*;
#(
  parameter int SYMW      = 4,
  parameter int PRIM_POLY = 19,
  parameter int N_SYM     = 15,
  parameter int NSYN      = 4,
  parameter int FCR       = 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [SYMW-1:0]      sym_i,
  input  logic                 sym_valid_i,
  output logic                 sym_ready_o,
  output logic [NSYN*SYMW-1:0] syn_o,
  output logic                 syn_valid_o,
  input  logic                 syn_ready_i,
  output logic                 err_o,
  output logic [7:0]           cw_cnt_o
`ifdef RS_SYN_ERRCNT_EN
  ,
  input  logic                 errcnt_clr_i,
  output logic [15:0]          errcnt_o
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(N_SYM - 1);

  logic [7:0]           cnt_q;
  logic [SYMW-1:0]      acc_q   [NSYN];
  logic [SYMW-1:0]      acc_d   [NSYN];
  logic [SYMW-1:0]      mul_out [NSYN];
  logic [NSYN*SYMW-1:0] syn_next;
  logic [NSYN*SYMW-1:0] syn_q;
  logic                 syn_valid_q;
  logic                 err_q;
  logic                 first_sym;
  logic                 last_sym;
  logic                 xfer;
  logic                 load_result;
  logic                 syn_nonzero;

  // One constant multiplier per root, fed by that root's accumulator.
  for (genvar j = 0; j < NSYN; j++) begin : g_root
    gf_mul_const #(
      .SYMW      (SYMW),
      .PRIM_POLY (PRIM_POLY),
      .POW       (FCR + j)
    ) u_mul (
      .a (acc_q[j]),
      .y (mul_out[j])
    );
  end

  // Handshake decode: stall only when the last symbol would overwrite an
  // unaccepted result.
  always_comb begin
    first_sym   = (cnt_q == 8'd0);
    last_sym    = (cnt_q == LAST_IDX);
    sym_ready_o = !(last_sym && syn_valid_q && !syn_ready_i);
    xfer        = sym_valid_i && sym_ready_o;
    load_result = xfer && last_sym;
  end

  // Horner step per root; the first symbol seeds the accumulator directly.
  always_comb begin
    syn_next = '0;
    for (int j = 0; j < NSYN; j++) begin
      acc_d[j] = first_sym ? sym_i : (mul_out[j] ^ sym_i);
      syn_next[j*SYMW +: SYMW] = acc_d[j];
    end
    syn_nonzero = (syn_next != '0);
  end

  // Symbol counter and accumulators advance only on a transfer.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      for (int j = 0; j < NSYN; j++) acc_q[j] <= '0;
    end else if (xfer) begin
      cnt_q <= last_sym ? 8'd0 : (cnt_q + 8'd1);
      for (int j = 0; j < NSYN; j++) acc_q[j] <= acc_d[j];
    end
  end

  // Result register: load on the last symbol, hold until accepted. A load in
  // the same cycle as acceptance keeps valid high with the new data.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      syn_q       <= '0;
      syn_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (load_result) begin
      syn_q       <= syn_next;
      syn_valid_q <= 1'b1;
      err_q       <= syn_nonzero;
    end else if (syn_valid_q && syn_ready_i) begin
      syn_valid_q <= 1'b0;
    end
  end

  assign syn_o       = syn_q;
  assign syn_valid_o = syn_valid_q;
  assign err_o       = err_q;
  assign cw_cnt_o    = cnt_q;

`ifdef RS_SYN_ERRCNT_EN
  logic [15:0] errcnt_q;

  // Saturating count of erroneous codewords; clear wins over increment.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      errcnt_q <= '0;
    end else if (errcnt_clr_i) begin
      errcnt_q <= '0;
    end else if (load_result && syn_nonzero && (errcnt_q != 16'hFFFF)) begin
      errcnt_q <= errcnt_q + 16'd1;
    end
  end

  assign errcnt_o = errcnt_q;
`endif

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Self-checking bench for rs_syndrome_calc (default parameters, GF(16)).
// The reference model evaluates the codeword polynomial directly at each root
// (sum of c_i * root^degree) and builds valid codewords as m(x)*g(x).
module tb_rs_syndrome_calc;

  localparam int SYMW      = 4;
  localparam int PRIM_POLY = 19;
  localparam int N_SYM     = 15;
  localparam int NSYN      = 4;
  localparam int FCR       = 1;
  localparam int Q         = 1 << SYMW;
  localparam int K_MSG     = N_SYM - NSYN;

  logic                 clk_i = 1'b0;
  logic                 rstn_i;
  logic [SYMW-1:0]      sym_i;
  logic                 sym_valid_i;
  logic                 sym_ready_o;
  logic [NSYN*SYMW-1:0] syn_o;
  logic                 syn_valid_o;
  logic                 syn_ready_i;
  logic                 err_o;
  logic [7:0]           cw_cnt_o;
`ifdef RS_SYN_ERRCNT_EN
  logic                 errcnt_clr_i;
  logic [15:0]          errcnt_o;
`endif

  rs_syndrome_calc #(
    .SYMW      (SYMW),
    .PRIM_POLY (PRIM_POLY),
    .N_SYM     (N_SYM),
    .NSYN      (NSYN),
    .FCR       (FCR)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .sym_i       (sym_i),
    .sym_valid_i (sym_valid_i),
    .sym_ready_o (sym_ready_o),
    .syn_o       (syn_o),
    .syn_valid_o (syn_valid_o),
    .syn_ready_i (syn_ready_i),
    .err_o       (err_o),
    .cw_cnt_o    (cw_cnt_o)
`ifdef RS_SYN_ERRCNT_EN
    ,
    .errcnt_clr_i(errcnt_clr_i),
    .errcnt_o    (errcnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int gmul(input int a, input int b);
    int r = 0;
    int x = a;
    for (int i = 0; i < SYMW; i++) begin
      if (b[i]) r = r ^ x;
      x = x << 1;
      if ((x & Q) != 0) x = x ^ PRIM_POLY;
    end
    return r;
  endfunction

  function automatic int gpow(input int a, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = gmul(r, a);
    return r;
  endfunction

  // c[0] is the highest-degree coefficient (degree N_SYM-1).
  function automatic logic [NSYN*SYMW-1:0] model_syn(input int c[N_SYM]);
    logic [NSYN*SYMW-1:0] packed_s = '0;
    for (int j = 0; j < NSYN; j++) begin
      int root = gpow(2, FCR + j);
      int s = 0;
      for (int i = 0; i < N_SYM; i++) s = s ^ gmul(c[i], gpow(root, N_SYM - 1 - i));
      packed_s[j*SYMW +: SYMW] = s[SYMW-1:0];
    end
    return packed_s;
  endfunction

  // Valid codeword = random message times the generator polynomial.
  task automatic make_valid(output int c[N_SYM]);
    int g[NSYN+1];
    int ng[NSYN+1];
    int m[K_MSG];
    int p[N_SYM];
    for (int k = 0; k <= NSYN; k++) g[k] = 0;
    g[0] = 1;
    for (int j = 0; j < NSYN; j++) begin
      int root = gpow(2, FCR + j);
      for (int k = 0; k <= NSYN; k++) ng[k] = gmul(g[k], root) ^ ((k > 0) ? g[k-1] : 0);
      g = ng;
    end
    for (int a = 0; a < K_MSG; a++) m[a] = $urandom_range(0, Q - 1);
    for (int k = 0; k < N_SYM; k++) p[k] = 0;
    for (int a = 0; a < K_MSG; a++)
      for (int b = 0; b <= NSYN; b++) p[a+b] = p[a+b] ^ gmul(m[a], g[b]);
    for (int i = 0; i < N_SYM; i++) c[i] = p[N_SYM - 1 - i];
  endtask

  task automatic make_corrupt(output int c[N_SYM]);
    int pos;
    make_valid(c);
    pos = $urandom_range(0, N_SYM - 1);
    c[pos] = c[pos] ^ $urandom_range(1, Q - 1);
  endtask

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; returns at the negedge after the symbol transferred.
  task automatic put(input int s);
    int n = 0;
    sym_i = s[SYMW-1:0];
    sym_valid_i = 1'b1;
    #1;
    while (!sym_ready_o && n < 40) begin
      @(negedge clk_i); #1;
      n++;
    end
    if (n >= 40) check("put_timeout", 32'(sym_ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    sym_valid_i = 1'b0;
  endtask

  task automatic send_cw(input int c[N_SYM], input bit gaps);
    for (int i = 0; i < N_SYM; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_i);
      put(c[i]);
    end
  endtask

  task automatic expect_result(input string tag, input logic [NSYN*SYMW-1:0] exp_syn,
                               input logic exp_err);
    check({tag, "_valid"}, 32'(syn_valid_o), 32'd1);
    check({tag, "_syn"},   32'(syn_o),       32'(exp_syn));
    check({tag, "_err"},   32'(err_o),       32'(exp_err));
  endtask

  int cw [N_SYM];
  int cw2[N_SYM];
  logic [NSYN*SYMW-1:0] exp_a, exp_b;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i = 1'b0;
    sym_i = '0;
    sym_valid_i = 1'b0;
    syn_ready_i = 1'b1;
`ifdef RS_SYN_ERRCNT_EN
    errcnt_clr_i = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Reset state
    check("rst_syn",   32'(syn_o),       32'h0);
    check("rst_valid", 32'(syn_valid_o), 32'h0);
    check("rst_err",   32'(err_o),       32'h0);
    check("rst_cnt",   32'(cw_cnt_o),    32'h0);
    check("rst_ready", 32'(sym_ready_o), 32'h1);
`ifdef RS_SYN_ERRCNT_EN
    check("rst_errcnt", 32'(errcnt_o), 32'h0);
`endif

    // All-zero codeword; valid appears exactly one cycle after symbol 15
    for (int i = 0; i < N_SYM - 1; i++) put(0);
    check("zero_pre_valid", 32'(syn_valid_o), 32'h0);
    check("zero_pre_cnt",   32'(cw_cnt_o),    32'(N_SYM - 1));
    put(0);
    expect_result("zero", 16'h0000, 1'b0);
    check("zero_cnt_wrap", 32'(cw_cnt_o), 32'h0);

    // Degree-0 coefficient = 1
    for (int i = 0; i < N_SYM; i++) cw[i] = 0;
    cw[N_SYM-1] = 1;
    send_cw(cw, 1'b0);
    expect_result("deg0", 16'h1111, 1'b1);
    check("deg0_model", 32'(syn_o), 32'(model_syn(cw)));

    // Degree-1 coefficient = 1
    for (int i = 0; i < N_SYM; i++) cw[i] = 0;
    cw[N_SYM-2] = 1;
    send_cw(cw, 1'b0);
    expect_result("deg1", 16'h3842, 1'b1);

    // Valid codewords with random gaps: all syndromes zero
    for (int t = 0; t < 4; t++) begin
      make_valid(cw);
      send_cw(cw, 1'b1);
      expect_result("valid_cw", model_syn(cw), 1'b0);
      check("valid_cw_zero", 32'(syn_o), 32'h0);
    end

    // Single-symbol corruption
    for (int t = 0; t < 4; t++) begin
      make_corrupt(cw);
      send_cw(cw, 1'b1);
      expect_result("corrupt", model_syn(cw), 1'b1);
    end

    // Back-to-back with syn_ready_i low
    make_corrupt(cw);
    exp_a = model_syn(cw);
    send_cw(cw, 1'b0);
    syn_ready_i = 1'b0;
    expect_result("bp_a", exp_a, 1'b1);
    make_valid(cw2);
    cw2[3] = cw2[3] ^ 5;
    exp_b = model_syn(cw2);
    for (int i = 0; i < N_SYM - 1; i++) put(cw2[i]);
    check("bp_a_hold_valid", 32'(syn_valid_o), 32'h1);
    check("bp_a_hold_syn",   32'(syn_o),       32'(exp_a));
    sym_i = cw2[N_SYM-1][SYMW-1:0];
    sym_valid_i = 1'b1;
    #1;
    check("bp_ready_low", 32'(sym_ready_o), 32'h0);
    @(negedge clk_i); #1;
    check("bp_ready_low2", 32'(sym_ready_o), 32'h0);
    check("bp_cnt_hold",   32'(cw_cnt_o),    32'(N_SYM - 1));
    check("bp_a_stable",   32'(syn_o),       32'(exp_a));
    syn_ready_i = 1'b1;
    #1;
    check("bp_ready_high", 32'(sym_ready_o), 32'h1);
    @(posedge clk_i);
    @(negedge clk_i);
    sym_valid_i = 1'b0;
    expect_result("bp_b", exp_b, 1'b1);
    check("bp_b_cnt", 32'(cw_cnt_o), 32'h0);
    @(negedge clk_i);
    check("bp_b_accepted", 32'(syn_valid_o), 32'h0);

    // Reset mid-codeword with a pending result
    syn_ready_i = 1'b0;
    make_corrupt(cw);
    send_cw(cw, 1'b0);
    make_corrupt(cw2);
    for (int i = 0; i < 7; i++) put(cw2[i]);
    check("mid_cnt", 32'(cw_cnt_o), 32'd7);
    rstn_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_syn",   32'(syn_o),       32'h0);
    check("mid_rst_valid", 32'(syn_valid_o), 32'h0);
    check("mid_rst_err",   32'(err_o),       32'h0);
    check("mid_rst_cnt",   32'(cw_cnt_o),    32'h0);
    check("mid_rst_ready", 32'(sym_ready_o), 32'h1);
    syn_ready_i = 1'b1;
    make_corrupt(cw);
    send_cw(cw, 1'b1);
    expect_result("after_rst", model_syn(cw), 1'b1);

`ifdef RS_SYN_ERRCNT_EN
    errcnt_clr_i = 1'b1;
    @(negedge clk_i);
    errcnt_clr_i = 1'b0;
    check("errcnt_clr0", 32'(errcnt_o), 32'h0);
    for (int t = 0; t < 3; t++) begin
      make_corrupt(cw);
      send_cw(cw, 1'b0);
    end
    make_valid(cw);
    send_cw(cw, 1'b0);
    @(negedge clk_i);
    check("errcnt_three", 32'(errcnt_o), 32'd3);
    errcnt_clr_i = 1'b1;
    @(negedge clk_i);
    errcnt_clr_i = 1'b0;
    check("errcnt_cleared", 32'(errcnt_o), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
